// File: rtl/fifo_rd_streamer_pkg.sv
// rtl/fifo_rd_streamer_pkg.sv - shared types and constants for the FIFO read streamer
// Contents: strm_state_e (IDLE/RUN/FLUSH), SKID_DEPTH, DEFAULT_WIDTH.
package fifo_rtl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } strm_state_e;

  // Three slots cover the two-cycle read-to-visible latency plus the word being
  // presented, which is what lets the streamer sustain one word per cycle.
  localparam int SKID_DEPTH    = 3;
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fifo_rd_streamer_if.sv
// rtl/fifo_rd_streamer_if.sv - FIFO read side plus output stream bundle
// Signals: empty, fifo_data (from FIFO); read (to FIFO);
//          m_valid, m_data, m_last (to sink); m_ready (from sink).
// Modports: master = streamer side, slave = FIFO/sink environment side.
interface fifo_rd_streamer_if #(
  parameter int WIDTH = fifo_rtl_pkg::DEFAULT_WIDTH
);
  logic             empty;
  logic [WIDTH-1:0] fifo_data;
  logic             read;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             m_ready;

  modport master (
    input  empty, fifo_data, m_ready,
    output read, m_valid, m_data, m_last
  );

  modport slave (
    output empty, fifo_data, m_ready,
    input  read, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_rd_streamer_skid_buf.sv
// rtl/fifo_rd_streamer_skid_buf.sv - 3-entry in-order push/pop buffer
// Ports: clock, reset (async, active-high), clear (drop contents),
//        push/push_data (tail write), pop (head remove), head, occ (0..3).
module fifo_skid_buf
  import fifo_rtl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [1:0]       occ_q;
  logic [1:0]       wr_idx;

  // Entries shift toward slot 0 on pop, so a simultaneous push lands one slot
  // lower than the current tail; the later NBA wins when the slots coincide.
  assign wr_idx = occ_q - {1'b0, pop};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      occ_q <= '0;
    end else if (clear) begin
      occ_q <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < SKID_DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      end
      if (push) mem_q[wr_idx] <= push_data;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem_q[0];
  assign occ  = occ_q;

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    push |-> (occ_q < 2'(SKID_DEPTH)));
  a_no_underflow: assert property (@(posedge clock) disable iff (reset)
    pop |-> (occ_q != 2'd0));

endmodule

// File: rtl/fifo_rd_streamer.sv
// rtl/fifo_rd_streamer.sv - FIFO read-side streamer with skid buffer and frame marking
// Ports: clock, reset (async, active-high), enable (allow reads),
//        flush (pulse: discard buffered/in-flight words), bus (fifo_rd_streamer_if.master).
// Optional: FIFO_STREAM_CNT_EN adds word_cnt[15:0], saturating transfer count.
module fifo_rd_streamer
  import fifo_rtl_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int BURST_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic flush,
`ifdef FIFO_STREAM_CNT_EN
  output logic [15:0] word_cnt,
`endif
  fifo_rd_streamer_if.master bus
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  strm_state_e      state_q, state_d;
  logic             rd_q;
  logic             issue_rd;
  logic [BW-1:0]    beat_q;
  logic [1:0]       occ;
  logic [WIDTH-1:0] head;
  logic [2:0]       committed;
  logic             push;
  logic             pop;

  // Buffered plus in-flight words; reading only when this is below the depth
  // guarantees every returning word has a slot, with no dependence on m_ready.
  assign committed = {1'b0, occ} + {2'b00, rd_q};

  always_comb begin
    state_d  = state_q;
    issue_rd = 1'b0;
    case (state_q)
      IDLE:  if (enable) state_d = RUN;
      RUN: begin
        issue_rd = !bus.empty && !flush && (committed < 3'(SKID_DEPTH));
        if (!enable) state_d = IDLE;
      end
      FLUSH: state_d = enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = FLUSH;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= issue_rd;
    end
  end

  // A word returning during the flush cycle or the FLUSH state is dropped.
  assign push = rd_q && !flush && (state_q != FLUSH);
  // Flush wins over the sink: a word shown during flush is not transferred.
  assign pop  = bus.m_valid && bus.m_ready && !flush;

  fifo_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .push_data (bus.fifo_data),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_q <= '0;
    end else if (flush) begin
      beat_q <= '0;
    end else if (pop) begin
      beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
    end
  end

  assign bus.read    = issue_rd;
  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = head;
  assign bus.m_last  = bus.m_valid && (beat_q == LAST_BEAT);

`ifdef FIFO_STREAM_CNT_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_cnt_q <= '0;
    end else if (flush) begin
      word_cnt_q <= '0;
    end else if (pop && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

  a_read_not_empty: assert property (@(posedge clock) disable iff (reset)
    bus.read |-> !bus.empty);

endmodule
